// File: rtl/floo_pkg.sv
// -----------------------------------------------------------------------------
// floo_pkg
// Shared types and defaults for the multicast fork controller.
//   route_direction_e  : bit index of each router output port in a route bitmap
//   mcast_fork_state_e : packet-lock state of the fork controller
//   DefaultNumRoutes   : default number of router output ports
//   DefaultStatsWidth  : default width of the stall-cycle counter
// -----------------------------------------------------------------------------
package floo_pkg;

   typedef enum logic [2:0] {
      Eject = 3'd0,
      North = 3'd1,
      East  = 3'd2,
      South = 3'd3,
      West  = 3'd4
   } route_direction_e;

   typedef enum logic {
      McIdle   = 1'b0,
      McLocked = 1'b1
   } mcast_fork_state_e;

   localparam int unsigned DefaultNumRoutes  = 5;
   localparam int unsigned DefaultStatsWidth = 32;

endpackage : floo_pkg

// File: rtl/floo_mcast_fork_ctrl_sat_cnt.sv
// -----------------------------------------------------------------------------
// floo_sat_cnt
// Saturating up-counter: increments by one on every cycle inc_i is high and
// sticks at all-ones instead of wrapping.
// Ports:
//   clk_i   in  1      clock
//   rst_ni  in  1      asynchronous active-low reset (clears the count)
//   inc_i   in  1      increment request
//   cnt_o   out Width  current count
// -----------------------------------------------------------------------------
module floo_sat_cnt #(
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] r_cnt;
   logic             w_full;

   assign w_full = &r_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (inc_i && !w_full) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt_o = r_cnt;

endmodule : floo_sat_cnt

// File: rtl/floo_mcast_fork_ctrl.sv
// -----------------------------------------------------------------------------
// floo_mcast_fork_ctrl
// Handshake controller for one router input carrying multicast flits. A single
// valid/ready stream is forked onto every output set in the route bitmap; the
// input is acked only once every selected output has taken the flit. Outputs
// that accept early are remembered and never offered the same flit again. The
// output set is locked from the head flit until the last flit of the packet.
//
// Optional feature: define FLOO_MCAST_FORK_STATS_EN to build a saturating
// stall-cycle counter on stall_cnt_o; otherwise stall_cnt_o is tied to zero.
//
// Ports:
//   clk_i        in  1           clock
//   rst_ni       in  1           asynchronous active-low reset
//   valid_i      in  1           input flit valid
//   ready_o      out 1           flit accepted by all selected outputs (comb.)
//   last_i       in  1           flit is last of packet
//   route_sel_i  in  NumRoutes   output bitmap for head flit (ignored locked)
//   valid_o      out NumRoutes   per-output valid (comb.)
//   ready_i      in  NumRoutes   per-output ready
//   sel_o        out NumRoutes   currently effective output bitmap
//   locked_o     out 1           packet in progress, selection held
//   drop_o       out 1           1-cycle pulse: flit with empty bitmap consumed
//   stall_cnt_o  out StatsWidth  saturating stall-cycle count
// -----------------------------------------------------------------------------
module floo_mcast_fork_ctrl
   import floo_pkg::*;
#(
   parameter int unsigned NumRoutes  = DefaultNumRoutes,
   parameter int unsigned StatsWidth = DefaultStatsWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  last_i,
   input  logic [NumRoutes-1:0]  route_sel_i,
   output logic [NumRoutes-1:0]  valid_o,
   input  logic [NumRoutes-1:0]  ready_i,
   output logic [NumRoutes-1:0]  sel_o,
   output logic                  locked_o,
   output logic                  drop_o,
   output logic [StatsWidth-1:0] stall_cnt_o
);

   mcast_fork_state_e r_state;
   mcast_fork_state_e w_state_next;

   logic [NumRoutes-1:0] r_sel;
   logic [NumRoutes-1:0] r_sent;
   logic                 r_drop;

   logic [NumRoutes-1:0] w_sel;
   logic [NumRoutes-1:0] w_valid;
   logic [NumRoutes-1:0] w_accept;
   logic                 w_done;
   logic                 w_hs;
   logic                 w_empty;

   // ---------------------------------------------------------------------------
   // Fork datapath (purely combinational, zero-cycle latency)
   // ---------------------------------------------------------------------------
   always_comb begin
      w_sel    = (r_state == McLocked) ? r_sel : route_sel_i;
      w_valid  = {NumRoutes{valid_i}} & w_sel & ~r_sent;
      w_accept = w_valid & ready_i;
      // An output is finished if it is not selected, already served, or
      // taking the flit right now; an empty bitmap is therefore done at once.
      w_done   = &(~w_sel | r_sent | w_accept);
      w_hs     = valid_i & w_done;
      w_empty  = ~|w_sel;
   end

   assign valid_o = w_valid;
   assign ready_o = w_hs;
   assign sel_o   = w_sel;
   assign drop_o  = r_drop;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= McIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: the default assignment at the top keeps this block free of latches
   // on paths that do not change state.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         McIdle: begin
            if (w_hs && !last_i) w_state_next = McLocked;
         end
         McLocked: begin
            if (w_hs && last_i) w_state_next = McIdle;
         end
         default: w_state_next = McIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      locked_o = (r_state == McLocked);
   end

   // ---------------------------------------------------------------------------
   // Selection lock, served-output tracking and drop pulse
   // ---------------------------------------------------------------------------
   // NOTE: these are control flops, not storage arrays, so all of them are
   // reset; a stale sent/sel bit after reset would suppress or misroute flits.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sel  <= '0;
         r_sent <= '0;
         r_drop <= 1'b0;
      end else begin
         // Head of a multi-flit packet: capture the bitmap for the whole packet.
         // A single-flit packet leaves the held selection untouched.
         if (r_state == McIdle && w_hs && !last_i) begin
            r_sel <= route_sel_i;
         end
         // Partial acceptance is remembered until the flit completes.
         if (w_hs) begin
            r_sent <= '0;
         end else begin
            r_sent <= r_sent | w_accept;
         end
         r_drop <= w_hs & w_empty;
      end
   end

   // ---------------------------------------------------------------------------
   // Optional stall statistics
   // ---------------------------------------------------------------------------
`ifdef FLOO_MCAST_FORK_STATS_EN
   logic w_stall;

   assign w_stall = valid_i & ~w_hs;

   floo_sat_cnt #(
      .Width (StatsWidth)
   ) i_stall_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (w_stall),
      .cnt_o  (stall_cnt_o)
   );
`else
   assign stall_cnt_o = '0;
`endif

endmodule : floo_mcast_fork_ctrl

// File: tb/tb_floo_mcast_fork_ctrl.sv
// -----------------------------------------------------------------------------
// tb_floo_mcast_fork_ctrl
// Directed bench for the multicast fork controller. Stall-counter expectations
// follow the FLOO_MCAST_FORK_STATS_EN setting of the build (counter width 4).
// -----------------------------------------------------------------------------
module tb_floo_mcast_fork_ctrl;

   localparam int unsigned NR = 5;
   localparam int unsigned SW = 4;
`ifdef FLOO_MCAST_FORK_STATS_EN
   localparam bit StatsOn = 1'b1;
`else
   localparam bit StatsOn = 1'b0;
`endif

   logic          clk_i;
   logic          rst_ni;
   logic          valid_i;
   logic          ready_o;
   logic          last_i;
   logic [NR-1:0] route_sel_i;
   logic [NR-1:0] valid_o;
   logic [NR-1:0] ready_i;
   logic [NR-1:0] sel_o;
   logic          locked_o;
   logic          drop_o;
   logic [SW-1:0] stall_cnt_o;

   int n_checks;
   int n_errors;

   floo_mcast_fork_ctrl #(
      .NumRoutes  (NR),
      .StatsWidth (SW)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .last_i      (last_i),
      .route_sel_i (route_sel_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .sel_o       (sel_o),
      .locked_o    (locked_o),
      .drop_o      (drop_o),
      .stall_cnt_o (stall_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_stall(input int n);
      if (!StatsOn) return 32'd0;
      return (n > 15) ? 32'd15 : n;
   endfunction

   // Input protocol monitor: a pending flit must keep its sideband stable.
   logic          p_pend;
   logic          p_last;
   logic [NR-1:0] p_sel;
   always @(posedge clk_i) begin
      if (!rst_ni) begin
         p_pend = 1'b0;
      end else begin
         if (p_pend) begin
            assert (valid_i && last_i == p_last && route_sel_i == p_sel)
               else $error("input protocol violated by stimulus");
         end
         p_pend = valid_i & ~ready_o;
         p_last = last_i;
         p_sel  = route_sel_i;
      end
   end

   task automatic drive(input logic v, input logic l, input logic [NR-1:0] s,
                        input logic [NR-1:0] r);
      valid_i     = v;
      last_i      = l;
      route_sel_i = s;
      ready_i     = r;
   endtask

   // Advance to the next posedge, then step 1 time unit into the new cycle.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, '0, '0);
      rst_ni = 1'b0;
      next_cycle();
      next_cycle();
      rst_ni = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      p_pend   = 1'b0;
      p_last   = 1'b0;
      p_sel    = '0;
      #1;
      do_reset();

      // ---- reset state ----
      @(negedge clk_i);
      check("rst_locked", locked_o, 0);
      check("rst_sel", sel_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_ready", ready_o, 0);
      check("rst_drop", drop_o, 0);
      check("rst_stall", stall_cnt_o, 0);
      next_cycle();

      // ---- single flit to N,E, both ready ----
      drive(1'b1, 1'b1, 5'b00110, 5'b11111);
      @(negedge clk_i);
      check("t1_valid", valid_o, 5'b00110);
      check("t1_ready", ready_o, 1);
      next_cycle();
      drive(1'b1, 1'b1, 5'b00110, 5'b00000);
      @(negedge clk_i);
      // Nothing remembered from the previous flit: both ports offered again.
      check("t1_sent_clear", valid_o, 5'b00110);
      check("t1_not_locked", locked_o, 0);
      drive(1'b1, 1'b1, 5'b00110, 5'b11111);
      next_cycle();
      drive(1'b0, 1'b0, '0, '0);

      // ---- partial acceptance: N ready, E waits 3 cycles ----
      do_reset();
      drive(1'b1, 1'b1, 5'b00110, 5'b00010);
      @(negedge clk_i);
      check("t2_c0_valid", valid_o, 5'b00110);
      check("t2_c0_ready", ready_o, 0);
      next_cycle();
      @(negedge clk_i);
      check("t2_c1_valid", valid_o, 5'b00100);
      check("t2_c1_ready", ready_o, 0);
      next_cycle();
      @(negedge clk_i);
      check("t2_c2_valid", valid_o, 5'b00100);
      next_cycle();
      drive(1'b1, 1'b1, 5'b00110, 5'b00110);
      @(negedge clk_i);
      check("t2_c3_valid", valid_o, 5'b00100);
      check("t2_c3_ready", ready_o, 1);
      next_cycle();
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clk_i);
      check("t2_stall", stall_cnt_o, exp_stall(3));
      check("t2_valid_idle", valid_o, 0);
      next_cycle();

      // ---- multi-flit packet locked to 00011 ----
      drive(1'b1, 1'b0, 5'b00011, 5'b11111);
      @(negedge clk_i);
      check("t3_head_valid", valid_o, 5'b00011);
      check("t3_head_ready", ready_o, 1);
      next_cycle();
      drive(1'b1, 1'b0, 5'b11000, 5'b11111);
      @(negedge clk_i);
      check("t3_b1_locked", locked_o, 1);
      check("t3_b1_sel", sel_o, 5'b00011);
      check("t3_b1_valid", valid_o, 5'b00011);
      next_cycle();
      drive(1'b1, 1'b1, 5'b11000, 5'b11111);
      @(negedge clk_i);
      check("t3_last_locked", locked_o, 1);
      check("t3_last_valid", valid_o, 5'b00011);
      check("t3_last_ready", ready_o, 1);
      next_cycle();
      drive(1'b0, 1'b0, 5'b11000, '0);
      @(negedge clk_i);
      check("t3_unlocked", locked_o, 0);
      check("t3_sel_follow", sel_o, 5'b11000);
      next_cycle();

      // ---- empty bitmap, single flit ----
      drive(1'b1, 1'b1, 5'b00000, 5'b00000);
      @(negedge clk_i);
      check("t4_ready", ready_o, 1);
      check("t4_valid", valid_o, 0);
      check("t4_drop_early", drop_o, 0);
      next_cycle();
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clk_i);
      check("t4_drop", drop_o, 1);
      next_cycle();
      @(negedge clk_i);
      check("t4_drop_end", drop_o, 0);
      next_cycle();

      // ---- empty bitmap head locks, body dropped ----
      drive(1'b1, 1'b0, 5'b00000, 5'b00000);
      next_cycle();
      drive(1'b1, 1'b0, 5'b11111, 5'b11111);
      @(negedge clk_i);
      check("t5_locked", locked_o, 1);
      check("t5_sel", sel_o, 0);
      check("t5_valid", valid_o, 0);
      check("t5_ready", ready_o, 1);
      check("t5_drop", drop_o, 1);
      next_cycle();
      drive(1'b1, 1'b1, 5'b11111, 5'b11111);
      next_cycle();
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clk_i);
      check("t5_unlocked", locked_o, 0);
      check("t5_drop_last", drop_o, 1);
      next_cycle();

      // ---- reset while locked with N already served ----
      drive(1'b1, 1'b0, 5'b00110, 5'b11111);
      next_cycle();
      drive(1'b1, 1'b0, 5'b00110, 5'b00010);
      @(negedge clk_i);
      check("t6_body_ready", ready_o, 0);
      next_cycle();
      @(negedge clk_i);
      check("t6_partial", valid_o, 5'b00100);
      check("t6_locked", locked_o, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("t6_rst_locked", locked_o, 0);
      check("t6_rst_sent", valid_o, 5'b00110);
      drive(1'b0, 1'b0, 5'b00000, 5'b00000);
      #1;
      check("t6_rst_valid", valid_o, 0);
      check("t6_rst_ready", ready_o, 0);
      check("t6_rst_sel", sel_o, 0);
      next_cycle();
      rst_ni = 1'b1;
      next_cycle();

      // ---- long stall: saturation / counter absent ----
      drive(1'b1, 1'b1, 5'b00001, 5'b00000);
      for (int i = 0; i < 20; i++) @(posedge clk_i);
      @(negedge clk_i);
      check("t7_stall20", stall_cnt_o, exp_stall(20));
      check("t7_wait_valid", valid_o, 5'b00001);
      for (int i = 0; i < 80; i++) @(posedge clk_i);
      @(negedge clk_i);
      check("t7_stall100", stall_cnt_o, exp_stall(100));
      ready_i = 5'b00001;
      next_cycle();
      drive(1'b0, 1'b0, '0, '0);
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_floo_mcast_fork_ctrl
